// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: funct3 access codes and LSU state encoding
package mem_stage_lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mem_stage_lsu_align.sv
// lsu_align: access legality, store lane placement and load extract/extend
module lsu_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic        store_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    output logic        legal_o,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);
    logic is_b, is_h;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;
    assign is_b = funct3_i == F3_B;
    assign is_h = funct3_i == F3_H;
    assign legal_o = is_b ? 1'b1 :
                     is_h ? ~addr_lo_i[0] :
                     funct3_i == F3_W  ? addr_lo_i == 2'b00 :
                     funct3_i == F3_BU ? ~store_i :
                     funct3_i == F3_HU ? ~store_i & ~addr_lo_i[0] : 1'b0;
    assign be_o = !store_i ? 4'b1111 :
                  is_b ? 4'b0001 << addr_lo_i :
                  is_h ? 4'b0011 << {addr_lo_i[1], 1'b0} : 4'b1111;
    assign wdata_o = !store_i ? 32'h0 :
                     is_b ? {4{wdata_i[7:0]}} :
                     is_h ? {2{wdata_i[15:0]}} : wdata_i;
    assign ld_b = 8'(rdata_i >> {ld_addr_lo_i, 3'b000});
    assign ld_h = 16'(rdata_i >> {ld_addr_lo_i[1], 4'b0000});
    assign ld_data_o = ld_funct3_i == F3_B  ? {{24{ld_b[7]}}, ld_b} :
                       ld_funct3_i == F3_H  ? {{16{ld_h[15]}}, ld_h} :
                       ld_funct3_i == F3_BU ? {24'h0, ld_b} :
                       ld_funct3_i == F3_HU ? {16'h0, ld_h} : rdata_i;
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: M-stage load/store unit driving a req/ack word bus
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 32,
    parameter logic [31:0] RESET_READ_DATA = 32'h0
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic [31:0]           ALUResultM,
    input  logic [31:0]           WriteDataM,
    input  logic [2:0]            funct3M,
    input  logic                  MemReadM,
    input  logic                  MemWriteM,
    input  logic                  FlushM,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [ADDR_WIDTH-1:0] dbus_addr,
    output logic [3:0]            dbus_be,
    output logic [31:0]           dbus_wdata,
    input  logic                  dbus_ack,
    input  logic [31:0]           dbus_rdata,
    output logic [31:0]           ReadDataM,
    output logic                  StallM,
    output logic                  MisalignM
);
    state_t state_q, state_d;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;
    logic        access, legal, launch;
    logic [3:0]  be;
    logic [31:0] wdata, ld_data;
    lsu_align u_align (
        .funct3_i    (funct3M),
        .store_i     (MemWriteM),
        .addr_lo_i   (ALUResultM[1:0]),
        .wdata_i     (WriteDataM),
        .legal_o     (legal),
        .be_o        (be),
        .wdata_o     (wdata),
        .ld_funct3_i (f3_q),
        .ld_addr_lo_i(lo_q),
        .rdata_i     (dbus_rdata),
        .ld_data_o   (ld_data)
    );
    assign access    = (MemReadM | MemWriteM) & ~FlushM;
    assign launch    = state_q == IDLE && access && legal;
    assign MisalignM = state_q == IDLE && access && !legal;
    assign StallM    = launch || state_q == BUSY;
    assign dbus_req  = state_q == BUSY;
    always_comb begin
        state_d = state_q == IDLE ? (launch ? BUSY : IDLE) :
                  state_q == BUSY ? (dbus_ack ? DONE : BUSY) : IDLE;
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_be    <= 4'h0;
            dbus_wdata <= 32'h0;
            f3_q       <= 3'h0;
            lo_q       <= 2'h0;
            ReadDataM  <= RESET_READ_DATA;
        end else begin
            state_q <= state_d;
            if (launch) begin
                dbus_we    <= MemWriteM;
                dbus_addr  <= ADDR_WIDTH'({ALUResultM[31:2], 2'b00});
                dbus_be    <= be;
                dbus_wdata <= wdata;
                f3_q       <= funct3M;
                lo_q       <= ALUResultM[1:0];
            end
            if (state_q == BUSY && dbus_ack && !dbus_we)
                ReadDataM <= ld_data;
        end
    end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed and randomized checks against a transaction-level model
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [31:0] ALUResultM = 32'h0, WriteDataM = 32'h0, dbus_rdata = 32'h0;
    logic [2:0]  funct3M = 3'h0;
    logic        MemReadM = 1'b0, MemWriteM = 1'b0, FlushM = 1'b0, dbus_ack = 1'b0;
    logic        dbus_req, dbus_we, StallM, MisalignM;
    logic [31:0] dbus_addr, dbus_wdata, ReadDataM;
    logic [3:0]  dbus_be;
    int          n_assert = 0, n_fail = 0;
    logic        chk_en = 1'b0;
    logic        m_busy, m_done, m_we;
    logic [31:0] m_addr, m_wd, m_rd;
    logic [3:0]  m_be;
    logic [2:0]  m_f3;
    logic [1:0]  m_lo;

    mem_stage_lsu #(.ADDR_WIDTH(32), .RESET_READ_DATA(32'h0)) dut (
        .clk(clk), .n_rst(n_rst), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .funct3M(funct3M), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .FlushM(FlushM),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .ReadDataM(ReadDataM), .StallM(StallM), .MisalignM(MisalignM)
    );

    always #5 clk = ~clk;

    function automatic logic legal_f(input logic [2:0] f3, input logic st, input logic [1:0] lo);
        case (f3)
            3'd0: return 1'b1;
            3'd1: return lo[0] == 1'b0;
            3'd2: return lo == 2'd0;
            3'd4: return !st;
            3'd5: return !st && lo[0] == 1'b0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] be_f(input logic [2:0] f3, input logic st, input logic [1:0] lo);
        if (!st || f3 == 3'd2) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << lo);
        return 4'(3 << (lo & 2'd2));
    endfunction

    function automatic logic [31:0] wd_f(input logic [2:0] f3, input logic [31:0] wd);
        if (f3 == 3'd0) return (wd & 32'hFF) * 32'h0101_0101;
        if (f3 == 3'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ext_f(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * lo)) & 32'hFF;
        h = (rd >> (16 * lo[1])) & 32'hFFFF;
        case (f3)
            3'd0: return b >= 128 ? b - 32'd256 : b;
            3'd1: return h >= 32768 ? h - 32'd65536 : h;
            3'd4: return b;
            3'd5: return h;
            default: return rd;
        endcase
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_we <= 1'b0; m_addr <= 32'h0;
            m_wd <= 32'h0; m_be <= 4'h0; m_f3 <= 3'h0; m_lo <= 2'h0; m_rd <= 32'h0;
        end else if (m_busy) begin
            if (dbus_ack) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                if (!m_we) m_rd <= ext_f(m_f3, m_lo, dbus_rdata);
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if ((MemReadM || MemWriteM) && !FlushM && legal_f(funct3M, MemWriteM, ALUResultM[1:0])) begin
            m_busy <= 1'b1;
            m_we   <= MemWriteM;
            m_addr <= ALUResultM & ~32'h3;
            m_be   <= be_f(funct3M, MemWriteM, ALUResultM[1:0]);
            m_wd   <= wd_f(funct3M, WriteDataM);
            m_f3   <= funct3M;
            m_lo   <= ALUResultM[1:0];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic idle_m, acc, lg;
            idle_m = !m_busy && !m_done;
            acc = (MemReadM || MemWriteM) && !FlushM;
            lg = legal_f(funct3M, MemWriteM, ALUResultM[1:0]);
            chk("m_req", 32'(dbus_req), 32'(m_busy));
            chk("m_stall", 32'(StallM), 32'(m_busy || (idle_m && acc && lg)));
            chk("m_misalign", 32'(MisalignM), 32'(idle_m && acc && !lg));
            chk("m_addr", dbus_addr, m_addr);
            chk("m_be", 32'(dbus_be), 32'(m_be));
            chk("m_we", 32'(dbus_we), 32'(m_we));
            if (m_we) chk("m_wdata", dbus_wdata, m_wd);
            chk("m_rdata", ReadDataM, m_rd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
        MemReadM = rd; MemWriteM = wr; funct3M = f3; ALUResultM = a;
    endtask

    task automatic store_case(input string nm, input logic [2:0] f3, input logic [31:0] a,
                              input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
        step();
        access(1'b0, 1'b1, f3, a);
        WriteDataM = 32'hAABB_CCDD;
        step();
        MemWriteM = 1'b0;
        dbus_ack = 1'b1;
        #1;
        chk({nm, "_be"}, 32'(dbus_be), 32'(ebe));
        chk({nm, "_wdata"}, dbus_wdata, ewd);
        chk({nm, "_we"}, 32'(dbus_we), 32'd1);
        step();
        dbus_ack = 1'b0;
        #1;
        chk({nm, "_rd_kept"}, ReadDataM, erd);
    endtask

    task automatic misalign_case(input string nm, input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
        step();
        access(rd, wr, f3, a);
        #1;
        chk({nm, "_mis"}, 32'(MisalignM), 32'd1);
        chk({nm, "_stall"}, 32'(StallM), 32'd0);
        step();
        access(1'b0, 1'b0, 3'd0, 32'h0);
        #1;
        chk({nm, "_noreq"}, 32'(dbus_req), 32'd0);
        chk({nm, "_mis_once"}, 32'(MisalignM), 32'd0);
    endtask

    initial begin
        int cnt;
        repeat (2) step();
        n_rst = 1'b1;
        chk_en = 1'b1;
        #1;
        chk("reset_rd", ReadDataM, 32'h0);
        chk("reset_stall", 32'(StallM), 32'd0);
        // LB, ack in the first BUSY cycle
        step();
        access(1'b1, 1'b0, 3'd0, 32'h1000_0003);
        #1;
        chk("lb_stall_t", 32'(StallM), 32'd1);
        step();
        MemReadM = 1'b0;
        dbus_ack = 1'b1;
        dbus_rdata = 32'h80FF_1234;
        #1;
        chk("lb_req", 32'(dbus_req), 32'd1);
        chk("lb_addr", dbus_addr, 32'h1000_0000);
        chk("lb_be", 32'(dbus_be), 32'hF);
        step();
        dbus_ack = 1'b0;
        #1;
        chk("lb_data", ReadDataM, 32'hFFFF_FF80);
        chk("lb_stall_t2", 32'(StallM), 32'd0);
        // LHU with three wait cycles
        step();
        access(1'b1, 1'b0, 3'd5, 32'h1000_0002);
        dbus_rdata = 32'h8001_0000;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 1) MemReadM = 1'b0;
            dbus_ack = k == 4;
            #1;
            if (StallM) cnt++;
            step();
        end
        dbus_ack = 1'b0;
        chk("lhu_stall_cycles", 32'(cnt), 32'd5);
        chk("lhu_data", ReadDataM, 32'h0000_8001);
        store_case("sb", 3'd0, 32'h1000_0001, 4'b0010, 32'hDDDD_DDDD, 32'h0000_8001);
        store_case("sh", 3'd1, 32'h1000_0002, 4'b1100, 32'hCCDD_CCDD, 32'h0000_8001);
        store_case("sw", 3'd2, 32'h1000_0000, 4'b1111, 32'hAABB_CCDD, 32'h0000_8001);
        misalign_case("lw_mis", 1'b1, 1'b0, 3'd2, 32'h1000_0002);
        misalign_case("sh_mis", 1'b0, 1'b1, 3'd1, 32'h1000_0001);
        // back-to-back LW then SW
        step();
        access(1'b1, 1'b0, 3'd2, 32'h1000_0004);
        step();
        MemReadM = 1'b0;
        dbus_ack = 1'b1;
        dbus_rdata = 32'h1234_5678;
        step();
        dbus_ack = 1'b0;
        access(1'b0, 1'b1, 3'd2, 32'h1000_0008);
        WriteDataM = 32'hCAFE_F00D;
        #1;
        chk("b2b_done_stall", 32'(StallM), 32'd0);
        chk("b2b_done_noreq", 32'(dbus_req), 32'd0);
        chk("b2b_lw_data", ReadDataM, 32'h1234_5678);
        step();
        #1;
        chk("b2b_sw_launch", 32'(StallM), 32'd1);
        step();
        MemWriteM = 1'b0;
        #1;
        chk("b2b_sw_req", 32'(dbus_req), 32'd1);
        chk("b2b_sw_addr", dbus_addr, 32'h1000_0008);
        chk("b2b_sw_wdata", dbus_wdata, 32'hCAFE_F00D);
        dbus_ack = 1'b1;
        step();
        dbus_ack = 1'b0;
        // flush in IDLE and during BUSY
        step();
        access(1'b1, 1'b0, 3'd2, 32'h2000_0000);
        FlushM = 1'b1;
        #1;
        chk("flush_idle_stall", 32'(StallM), 32'd0);
        step();
        FlushM = 1'b0;
        #1;
        chk("flush_idle_noreq", 32'(dbus_req), 32'd0);
        chk("flush_relaunch", 32'(StallM), 32'd1);
        step();
        MemReadM = 1'b0;
        FlushM = 1'b1;
        #1;
        chk("flush_busy_req", 32'(dbus_req), 32'd1);
        step();
        #1;
        chk("flush_busy_req2", 32'(dbus_req), 32'd1);
        FlushM = 1'b0;
        dbus_ack = 1'b1;
        dbus_rdata = 32'h0BAD_F00D;
        step();
        dbus_ack = 1'b0;
        // reset while BUSY
        step();
        access(1'b1, 1'b0, 3'd2, 32'h3000_0000);
        step();
        MemReadM = 1'b0;
        #1;
        chk("rst_pre_req", 32'(dbus_req), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("rst_req", 32'(dbus_req), 32'd0);
        chk("rst_stall", 32'(StallM), 32'd0);
        chk("rst_rd", ReadDataM, 32'h0);
        step();
        n_rst = 1'b1;
        #1;
        chk("rst_idle_req", 32'(dbus_req), 32'd0);
        chk("rst_idle_stall", 32'(StallM), 32'd0);
        // randomized traffic, including spurious acks and flushes
        for (int i = 0; i < 3000; i++) begin
            step();
            MemReadM   = $urandom_range(0, 1) == 1;
            MemWriteM  = $urandom_range(0, 2) == 0;
            FlushM     = $urandom_range(0, 7) == 0;
            funct3M    = 3'($urandom_range(0, 7));
            ALUResultM = $urandom;
            WriteDataM = $urandom;
            dbus_ack   = $urandom_range(0, 2) == 0;
            dbus_rdata = $urandom;
            if (i % 700 == 350) begin
                n_rst = 1'b0;
                #1;
                n_rst = 1'b1;
            end
        end
        step();
        access(1'b0, 1'b0, 3'd0, 32'h0);
        dbus_ack = 1'b0;
        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs (ALUResultM as address, WriteDataM, funct3M, RdM-side control) and drives a word-wide data bus with a req/ack handshake. It generates byte enables and lane-replicated store data, and returns sign/zero-extended load data. It stalls the pipeline while a bus transaction is outstanding and flags misaligned or illegal accesses.

Parameters:
ADDR_WIDTH, 32, data bus address width; ALUResultM is truncated/zero-extended to this width.
RESET_READ_DATA, 32'h0, reset value of ReadDataM.

Ports:
clk  input  1  clock; all state updates on rising edge
n_rst  input  1  asynchronous active-low reset
ALUResultM  input  32  effective byte address
WriteDataM  input  32  store source (rs2)
funct3M  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
MemReadM  input  1  load in M stage
MemWriteM  input  1  store in M stage
FlushM  input  1  squash M-stage access (honoured in IDLE only)
dbus_req  output  1  bus request, held until ack
dbus_we  output  1  1 = write
dbus_addr  output  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
dbus_be  output  4  byte enables
dbus_wdata  output  32  lane-replicated store data
dbus_ack  input  1  one-cycle completion strobe; dbus_rdata valid with it
dbus_rdata  input  32  read word
ReadDataM  output  32  extended load result, registered
StallM  output  1  hold IF..M stages this cycle
MisalignM  output  1  misaligned/illegal access, one cycle per attempt

Behaviour:
- Interface: single clock clk; reset n_rst is asynchronous, active-low.
- Reset: state=IDLE, dbus_req=0, dbus_we=0, dbus_addr=0, dbus_be=0, dbus_wdata=0, ReadDataM=RESET_READ_DATA, StallM=0, MisalignM=0.
- access = (MemReadM|MemWriteM) & ~FlushM. A store takes priority when both MemReadM and MemWriteM are set.
- Legality check: W requires addr[1:0]=00. H/HU requires addr[0]=0. funct3 011/110/111 is illegal. Store with funct3 100/101 is illegal.
- FSM states: IDLE, BUSY, DONE.
- IDLE, legal access:
  - StallM=1 combinationally.
  - Register dbus_addr={addr[31:2],2'b00}, dbus_we, dbus_be, dbus_wdata.
  - Next state BUSY.
- IDLE, illegal access:
  - MisalignM=1 combinationally for that cycle; StallM=0; no bus activity; stay IDLE.
- BUSY:
  - dbus_req=1; StallM=1; bus outputs stable.
  - On dbus_ack: for loads, ReadDataM <= extend(dbus_rdata); stores leave ReadDataM unchanged. Next state DONE; dbus_req drops the following cycle.
  - No timeout; FlushM is ignored while BUSY.
- DONE:
  - StallM=0, so the pipeline advances at this edge.
  - No new launch in this cycle, which prevents re-issuing the same instruction.
  - Next state IDLE.
- Latency: access in M at cycle T; req asserted T+1; with ack at T+1, ReadDataM is valid and StallM=0 in T+2. Each wait cycle adds one.
- Store lanes:
  - SB: be=0001<<addr[1:0], wdata={4{WriteDataM[7:0]}}.
  - SH: be=0011<<{addr[1],0}, wdata={2{WriteDataM[15:0]}}.
  - SW: be=1111, wdata=WriteDataM.
  - Loads drive be=1111.
- Load extract:
  - byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
  - B/H sign-extend, BU/HU zero-extend, W passes through.
  - The low address bits used are the registered copies.
- Spurious dbus_ack in IDLE/DONE: ignored.
- Reset mid-transaction: immediate return to IDLE with dbus_req=0; the transaction is abandoned.

Decomposition:
- Shared package: funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- Sub-module lsu_align (combinational): legality check, be/wdata generation, and load extract/extend. The top level holds the FSM and registers.

Test Plan:
- Reset with n_rst=0 mid-BUSY -> dbus_req=0 the same cycle, ReadDataM=0, StallM=0, state IDLE after release.
- LB at addr 0x1000_0003, rdata=0x80FF_1234 with ack at T+1 -> dbus_addr=0x1000_0000, be=1111, ReadDataM=0xFFFF_FF80 at T+2, StallM high for T and T+1 only.
- LHU at 0x1000_0002, rdata=0x8001_0000, ack after 3 wait cycles -> ReadDataM=0x0000_8001, StallM high for exactly 5 cycles.
- Stores at 0x1000_0001, WriteDataM=0xAABB_CCDD:
  - SB -> be=0010, wdata=0xDDDD_DDDD.
  - SH at 0x1000_0002 -> be=1100, wdata=0xCCDD_CCDD.
  - SW at 0x1000_0000 -> be=1111, wdata=0xAABB_CCDD; ReadDataM unchanged.
- LW at 0x1000_0002 and SH at 0x1000_0001 -> MisalignM=1 for one cycle each, dbus_req never asserted, StallM=0.
- Back-to-back LW then SW -> the second request starts in the cycle after DONE; FlushM=1 in IDLE suppresses the launch; FlushM=1 during BUSY does not drop dbus_req.
